sector_buf_arbiter: RTL and testbench

- Shares the single-port 512x8 sector buffer between two requesters: the 6502 workhorse CPU (port A) and the WD1793 emulation core (port B).
- Replaces ad-hoc address/write-enable muxing with a registered request/acknowledge scheduler.
- Provides round-robin or fixed priority, a B-side burst lock for whole-sector transfers, and a lock watchdog so the CPU cannot be starved.
- Sits between both requesters and the buffer RAM, which is clocked on the rising edge of clk.

---
 rtl/sector_buf_arbiter.sv | 134 +++++++++++++
 tb/tb_sector_buf_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sector_buf_arbiter.sv
// Request/acknowledge scheduler sharing the single-port sector buffer between
// the 6502 CPU (port A) and the WD1793 core (port B), with burst lock and watchdog.
module sector_buf_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 8,
  parameter int B_FIXED_PRIO = 0,
  parameter int LOCK_MAX     = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  state_t            state;
  owner_t            owner;
  logic              last_grant_b;
  logic              rd_pend;
  logic [CNT_W-1:0]  lock_cnt;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic wd_expired;
  logic a_excluded;
  logic grant_a;
  logic grant_b;

  assign wd_expired = (lock_cnt == CNT_W'(LOCK_MAX));
  assign a_excluded = b_lock && (owner == OWN_B) && !wd_expired;

  // An expired watchdog overrides both the lock and fixed priority for one A grant.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (wd_expired && a_req) begin
      grant_a = 1'b1;
    end else if (a_excluded) begin
      grant_b = b_req;
    end else if (a_req && b_req) begin
      if (B_FIXED_PRIO != 0)  grant_b = 1'b1;
      else if (last_grant_b)  grant_a = 1'b1;
      else                    grant_b = 1'b1;
    end else begin
      grant_a = a_req;
      grant_b = b_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      last_grant_b <= 1'b1;
      rd_pend      <= 1'b0;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_di       <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (state == IDLE && grant_a) begin
        lock_cnt <= '0;
        if (wd_expired) lock_timeout <= 1'b1;
      end else if (a_req && a_excluded) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (grant_a || grant_b) begin
            state        <= ISSUE;
            owner        <= grant_a ? OWN_A : OWN_B;
            last_grant_b <= grant_b;
            ram_addr     <= grant_a ? a_addr  : b_addr;
            ram_we       <= grant_a ? a_we    : b_we;
            ram_di       <= grant_a ? a_wdata : b_wdata;
            rd_pend      <= grant_a ? !a_we   : !b_we;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          state  <= DATA;
          a_ack  <= (owner == OWN_A);
          b_ack  <= (owner == OWN_B);
        end
        DATA: begin
          state <= IDLE;
          if (rd_pend && owner == OWN_A) a_rdata_q <= ram_q;
          if (rd_pend && owner == OWN_B) b_rdata_q <= ram_q;
        end
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // The RAM's read data only exists during the ack cycle, so it is forwarded there.
  assign a_rdata = (a_ack && rd_pend) ? ram_q : a_rdata_q;
  assign b_rdata = (b_ack && rd_pend) ? ram_q : b_rdata_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_sector_buf_arbiter.sv
// Directed bench for sector_buf_arbiter: single-access vectors, round-robin and
// fixed-priority ties, burst lock watchdog and reset during an access.
module tb_sector_buf_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we, b_lock;
  logic [8:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_ack, b_ack, ram_we, busy, lock_timeout;
  logic [7:0] a_rdata, b_rdata, ram_di, ram_q;
  logic [8:0] ram_addr;

  logic       fp_a_ack, fp_b_ack, fp_ram_we, fp_busy, fp_lock_timeout;
  logic [7:0] fp_a_rdata, fp_b_rdata, fp_ram_di, fp_ram_q;
  logic [8:0] fp_ram_addr;

  logic       pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sector_buf_arbiter #(.ADDR_W(9), .DATA_W(8), .B_FIXED_PRIO(0), .LOCK_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_lock(b_lock),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_q(ram_q),
    .busy(busy), .lock_timeout(lock_timeout)
  );

  sector_buf_arbiter #(.ADDR_W(9), .DATA_W(8), .B_FIXED_PRIO(1), .LOCK_MAX(8)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(fp_b_ack), .b_rdata(fp_b_rdata), .b_lock(b_lock),
    .ram_addr(fp_ram_addr), .ram_we(fp_ram_we), .ram_di(fp_ram_di), .ram_q(fp_ram_q),
    .busy(fp_busy), .lock_timeout(fp_lock_timeout)
  );

  // Synchronous-read buffer models, one per DUT, with a bench preload port.
  always @(posedge clk) begin
    if (pre_we) mem0[pre_addr] <= pre_data;
    else if (ram_we) mem0[ram_addr] <= ram_di;
    ram_q <= mem0[ram_addr];
  end

  always @(posedge clk) begin
    if (pre_we) mem1[pre_addr] <= pre_data;
    else if (fp_ram_we) mem1[fp_ram_addr] <= fp_ram_di;
    fp_ram_q <= mem1[fp_ram_addr];
  end

  typedef struct {
    logic       side_b;
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] model_a_rdata;
  logic [7:0] model_b_rdata;

  int rr_side [8];
  int rr_cyc  [8];
  int rr_n;
  int fp_a_cnt, fp_b_cnt;
  int nb, a_started, a_seen, after_side;
  logic lt_before, lt_at_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after the ack.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.side_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    tick();
    check_output({tag, "_issue_addr"}, 32'(ram_addr), 32'(v.addr));
    check_output({tag, "_issue_we"}, 32'(ram_we), 32'(v.we));
    check_output({tag, "_issue_busy"}, 32'(busy), 32'd1);
    if (v.we) check_output({tag, "_issue_di"}, 32'(ram_di), 32'(v.wdata));
    tick();
    check_output({tag, "_data_we"}, 32'(ram_we), 32'd0);
    check_output({tag, "_data_a_ack"}, 32'(a_ack), 32'(!v.side_b));
    check_output({tag, "_data_b_ack"}, 32'(b_ack), 32'(v.side_b));
    if (!v.we) begin
      if (v.side_b) model_b_rdata = v.exp_rdata;
      else          model_a_rdata = v.exp_rdata;
      check_output({tag, "_ack_rdata"}, 32'(v.side_b ? b_rdata : a_rdata), 32'(v.exp_rdata));
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    check_output({tag, "_idle_acks"}, 32'({a_ack, b_ack}), 32'd0);
    check_output({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_held_a_rdata"}, 32'(a_rdata), 32'(model_a_rdata));
    check_output({tag, "_held_b_rdata"}, 32'(b_rdata), 32'(model_b_rdata));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 9'h005, 8'h00, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 9'h1FF, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 9'h1FF, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 9'h005, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 9'h000, 8'h5A, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 9'h000, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 1'b1, 9'h100, 8'hFF, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 9'h100, 8'h00, 8'hFF};

    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    b_lock = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    model_a_rdata = 8'h00;
    model_b_rdata = 8'h00;

    tick();
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_ram_we", 32'(ram_we), 32'd0);
    check_output("rst_ram_di", 32'(ram_di), 32'd0);
    check_output("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    check_output("rst_a_rdata", 32'(a_rdata), 32'd0);
    check_output("rst_b_rdata", 32'(b_rdata), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_lock_timeout", 32'(lock_timeout), 32'd0);

    pre_we = 1'b1; pre_addr = 9'h005; pre_data = 8'h3C;
    tick();
    pre_addr = 9'h0AA; pre_data = 8'h11;
    tick();
    pre_we = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

    // Both sides requesting continuously: A,B,A,B every 3 cycles; fixed-priority copy only B.
    reset_dut();
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'h1FF;
    rr_n = 0; fp_a_cnt = 0; fp_b_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (a_ack && rr_n < 8) begin rr_side[rr_n] = 0; rr_cyc[rr_n] = i; rr_n++; end
      if (b_ack && rr_n < 8) begin rr_side[rr_n] = 1; rr_cyc[rr_n] = i; rr_n++; end
      if (fp_a_ack) fp_a_cnt++;
      if (fp_b_ack) fp_b_cnt++;
    end
    a_req = 1'b0; b_req = 1'b0;
    check_output("rr_ack_count", 32'(rr_n), 32'd4);
    if (rr_n >= 4) begin
      check_output("rr_first_cycle", 32'(rr_cyc[0]), 32'd2);
      for (int k = 0; k < 4; k++) check_output($sformatf("rr_order%0d", k), 32'(rr_side[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) check_output($sformatf("rr_spacing%0d", k), 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd3);
    end
    check_output("fp_b_acks", 32'(fp_b_cnt), 32'd4);
    check_output("fp_a_acks", 32'(fp_a_cnt), 32'd0);

    // B holds the lock; A raised on B's first ack is starved until the watchdog fires.
    reset_dut();
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010; b_lock = 1'b1;
    nb = 0; a_started = 0; a_seen = 0; after_side = -1;
    lt_before = 1'bx; lt_at_a = 1'bx;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_started == 0) begin
        if (b_ack) begin
          a_started = 1; a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
        end
      end else if (a_seen == 0) begin
        if (b_ack) begin
          nb++;
          if (nb == 1) lt_before = lock_timeout;
        end
        if (a_ack) begin
          a_seen = 1; lt_at_a = lock_timeout; a_req = 1'b0;
        end
      end else if (after_side < 0) begin
        if (b_ack) after_side = 1;
        else if (a_ack) after_side = 0;
      end
    end
    b_req = 1'b0; b_lock = 1'b0;
    check_output("lock_a_acked", 32'(a_seen), 32'd1);
    check_output("lock_b_acks_before_a", 32'(nb), 32'd3);
    check_output("lock_timeout_before", 32'(lt_before), 32'd0);
    check_output("lock_timeout_at_a", 32'(lt_at_a), 32'd1);
    check_output("lock_b_resumes", 32'(after_side), 32'd1);
    tick(); tick(); tick();
    check_output("lock_timeout_sticky", 32'(lock_timeout), 32'd1);

    // Reset arriving during ISSUE of an A write must abort it without touching the RAM.
    a_req = 1'b1; a_we = 1'b1; a_addr = 9'h0AA; a_wdata = 8'h77;
    tick();
    check_output("abort_issue_we", 32'(ram_we), 32'd1);
    check_output("abort_issue_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("abort_ram_we", 32'(ram_we), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    a_req = 1'b0;
    tick();
    check_output("abort_a_ack0", 32'(a_ack), 32'd0);
    tick();
    check_output("abort_mem_unchanged", 32'(mem0[9'h0AA]), 32'h11);
    check_output("abort_lock_timeout_clr", 32'(lock_timeout), 32'd0);
    reset_n = 1'b1;
    tick();
    check_output("abort_a_ack1", 32'(a_ack), 32'd0);
    check_output("abort_idle_busy", 32'(busy), 32'd0);
    tick();
    check_output("abort_a_ack2", 32'(a_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
